// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared state encoding and defaults for the keypad lock
package lock_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_CHECK   = 2'd1,
        ST_OPEN    = 2'd2,
        ST_LOCKOUT = 2'd3
    } lock_state_t;

    localparam logic LOW  = 1'b0;
    localparam logic HIGH = 1'b1;

    localparam int              DEFAULT_CODE_LEN = 5;
    localparam logic [4:0]      DEFAULT_CODE     = 5'b01011;

endpackage

// File: rtl/edge_detect_rise.sv
// rtl/edge_detect_rise.sv - registered rising-edge detector for keypad strobes
module edge_detect_rise (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);
    import lock_pkg::*;

    logic level_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_prev <= LOW;
        end else begin
            level_prev <= level;
        end
    end

    assign rise = level & ~level_prev;

endmodule

// File: rtl/lock_controller.sv
// rtl/lock_controller.sv - combination lock sequencer with timed unlock and lockout
module lock_controller #(
    parameter int                  CODE_LEN       = lock_pkg::DEFAULT_CODE_LEN,
    parameter logic [CODE_LEN-1:0] CODE           = lock_pkg::DEFAULT_CODE,
    parameter int                  MAX_FAIL       = 3,
    parameter int                  OPEN_CYCLES    = 8,
    parameter int                  LOCKOUT_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              update,
    input  logic                              key,
    input  logic                              relock,
    output logic                              unlock,
    output logic                              lockout,
    output logic [$clog2(CODE_LEN+1)-1:0]     digit_count,
    output logic [$clog2(MAX_FAIL+1)-1:0]     fail_count
);
    import lock_pkg::*;

    localparam int DC_W  = $clog2(CODE_LEN + 1);
    localparam int FC_W  = $clog2(MAX_FAIL + 1);
    localparam int T_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    lock_state_t         state;
    logic [CODE_LEN-1:0] shift;
    logic [TW-1:0]       timer;
    logic                key_edge;

    edge_detect_rise u_update_edge (
        .clk   (clk),
        .reset (reset),
        .level (update),
        .rise  (key_edge)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_ENTRY;
            shift       <= '0;
            digit_count <= '0;
            fail_count  <= '0;
            timer       <= '0;
            unlock      <= LOW;
            lockout     <= LOW;
        end else begin
            case (state)
                ST_ENTRY: begin
                    // relock aborts a partial entry and wins over a same-cycle key edge
                    if (relock) begin
                        shift       <= '0;
                        digit_count <= '0;
                    end else if (key_edge) begin
                        shift       <= {shift[CODE_LEN-2:0], key};
                        digit_count <= digit_count + DC_W'(1);
                        if (digit_count == DC_W'(CODE_LEN - 1)) begin
                            state <= ST_CHECK;
                        end
                    end
                end

                ST_CHECK: begin
                    shift       <= '0;
                    digit_count <= '0;
                    if (shift == CODE) begin
                        fail_count <= '0;
                        timer      <= TW'(OPEN_CYCLES - 1);
                        unlock     <= HIGH;
                        state      <= ST_OPEN;
                    end else if (fail_count == FC_W'(MAX_FAIL - 1)) begin
                        fail_count <= '0;
                        timer      <= TW'(LOCKOUT_CYCLES - 1);
                        lockout    <= HIGH;
                        state      <= ST_LOCKOUT;
                    end else begin
                        fail_count <= fail_count + FC_W'(1);
                        state      <= ST_ENTRY;
                    end
                end

                ST_OPEN: begin
                    if (relock || timer == '0) begin
                        unlock <= LOW;
                        state  <= ST_ENTRY;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                ST_LOCKOUT: begin
                    if (timer == '0) begin
                        lockout <= LOW;
                        state   <= ST_ENTRY;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                default: begin
                    unlock  <= LOW;
                    lockout <= LOW;
                    state   <= ST_ENTRY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_controller.sv
// tb/tb_lock_controller.sv - scoreboard bench for lock_controller
module tb_lock_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       update;
    logic       key;
    logic       relock;
    logic       unlock;
    logic       lockout;
    logic [2:0] digit_count;
    logic [1:0] fail_count;

    localparam logic [4:0] GOOD  = 5'b01011;
    localparam logic [4:0] WRONG = 5'b11111;

    // expected {unlock, lockout, digit_count, fail_count} once an entry has been checked
    typedef struct {
        string      name;
        logic [6:0] value;
    } exp_t;

    exp_t sb[$];
    int   errors     = 0;
    int   checks     = 0;
    int   model_fail = 0;

    always #5 clk = ~clk;

    lock_controller #(
        .CODE_LEN       (5),
        .CODE           (GOOD),
        .MAX_FAIL       (3),
        .OPEN_CYCLES    (8),
        .LOCKOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .update      (update),
        .key         (key),
        .relock      (relock),
        .unlock      (unlock),
        .lockout     (lockout),
        .digit_count (digit_count),
        .fail_count  (fail_count)
    );

    function automatic logic [6:0] observed();
        return {unlock, lockout, digit_count, fail_count};
    endfunction

    task automatic apply_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_fail = 0;
    endtask

    task automatic key_pulse(input logic k);
        @(negedge clk);
        update = 1'b1;
        key    = k;
        @(negedge clk);
        update = 1'b0;
    endtask

    // drives one full entry MSB first and queues the outcome it must produce
    task automatic enter_code(input string name, input logic [4:0] bits);
        exp_t e;
        e.name = name;
        if (bits == GOOD) begin
            model_fail = 0;
            e.value = {1'b1, 1'b0, 3'd0, 2'd0};
        end else if (model_fail + 1 == 3) begin
            model_fail = 0;
            e.value = {1'b0, 1'b1, 3'd0, 2'd0};
        end else begin
            model_fail++;
            e.value = {1'b0, 1'b0, 3'd0, 2'(model_fail)};
        end
        sb.push_back(e);
        for (int i = 4; i >= 0; i--) begin
            key_pulse(bits[i]);
        end
    endtask

    task automatic wait_unlock_low(input string name);
        int budget;
        budget = 0;
        while (unlock === 1'b1 && budget < 40) begin
            budget++;
            @(negedge clk);
        end
        checks++;
        if (unlock !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: unlock=%b required 0", name, unlock);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (observed() !== 7'd0) begin
            errors++;
            $display("FAIL reset_state: got %b required %b", observed(), 7'd0);
        end
    endtask

    task automatic test_correct();
        exp_t e;
        int   cnt;
        enter_code("correct", GOOD);
        checks++;
        if (observed() !== {1'b0, 1'b0, 3'd5, 2'd0}) begin
            errors++;
            $display("FAIL correct_check_cycle: got %b required %b", observed(), {1'b0, 1'b0, 3'd5, 2'd0});
        end
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (observed() !== e.value) begin
            errors++;
            $display("FAIL %s: got %b required %b", e.name, observed(), e.value);
        end
        cnt = 0;
        while (unlock === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt !== 8) begin
            errors++;
            $display("FAIL correct_open_len: got %0d required 8", cnt);
        end
    endtask

    task automatic test_wrong();
        exp_t e;
        enter_code("wrong", WRONG);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (observed() !== e.value) begin
            errors++;
            $display("FAIL %s: got %b required %b", e.name, observed(), e.value);
        end
    endtask

    task automatic test_lockout();
        exp_t e;
        int   cnt;
        logic dc_moved;
        apply_reset();
        for (int n = 0; n < 3; n++) begin
            enter_code($sformatf("lockout_wrong%0d", n), WRONG);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (observed() !== e.value) begin
                errors++;
                $display("FAIL %s: got %b required %b", e.name, observed(), e.value);
            end
        end
        cnt      = 0;
        dc_moved = 1'b0;
        while (lockout === 1'b1 && cnt < 40) begin
            if (digit_count !== 3'd0) dc_moved = 1'b1;
            update = (cnt % 2 == 1);
            key    = 1'b1;
            cnt++;
            @(negedge clk);
        end
        update = 1'b0;
        checks++;
        if (cnt !== 16) begin
            errors++;
            $display("FAIL lockout_len: got %0d required 16", cnt);
        end
        @(negedge clk);
        checks++;
        if (dc_moved || digit_count !== 3'd0) begin
            errors++;
            $display("FAIL lockout_edges_ignored: digit_count=%0d moved=%b required 0", digit_count, dc_moved);
        end
        enter_code("after_lockout", GOOD);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (observed() !== e.value) begin
            errors++;
            $display("FAIL %s: got %b required %b", e.name, observed(), e.value);
        end
        wait_unlock_low("after_lockout");
    endtask

    task automatic test_relock_open();
        exp_t e;
        apply_reset();
        enter_code("relock_open_entry", GOOD);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (observed() !== e.value) begin
            errors++;
            $display("FAIL %s: got %b required %b", e.name, observed(), e.value);
        end
        repeat (2) @(negedge clk);
        relock = 1'b1;
        @(negedge clk);
        relock = 1'b0;
        checks++;
        if (observed() !== 7'd0) begin
            errors++;
            $display("FAIL relock_open_drop: got %b required %b", observed(), 7'd0);
        end
    endtask

    task automatic test_relock_entry();
        exp_t e;
        apply_reset();
        enter_code("relock_entry_wrong", WRONG);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (observed() !== e.value) begin
            errors++;
            $display("FAIL %s: got %b required %b", e.name, observed(), e.value);
        end
        key_pulse(1'b0);
        key_pulse(1'b1);
        key_pulse(1'b0);
        checks++;
        if (digit_count !== 3'd3) begin
            errors++;
            $display("FAIL relock_entry_partial: digit_count=%0d required 3", digit_count);
        end
        relock = 1'b1;
        @(negedge clk);
        relock = 1'b0;
        checks++;
        if (observed() !== {1'b0, 1'b0, 3'd0, 2'd1}) begin
            errors++;
            $display("FAIL relock_entry_abort: got %b required %b", observed(), {1'b0, 1'b0, 3'd0, 2'd1});
        end
    endtask

    task automatic test_held_strobe();
        apply_reset();
        @(negedge clk);
        update = 1'b1;
        key    = 1'b1;
        repeat (20) @(negedge clk);
        update = 1'b0;
        checks++;
        if (digit_count !== 3'd1) begin
            errors++;
            $display("FAIL held_strobe: digit_count=%0d required 1", digit_count);
        end
        @(negedge clk);
        update = 1'b1;
        relock = 1'b1;
        @(negedge clk);
        update = 1'b0;
        relock = 1'b0;
        checks++;
        if (digit_count !== 3'd0) begin
            errors++;
            $display("FAIL edge_with_relock: digit_count=%0d required 0", digit_count);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        apply_reset();
        enter_code("async_pre", GOOD);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (observed() !== e.value) begin
            errors++;
            $display("FAIL %s: got %b required %b", e.name, observed(), e.value);
        end
        @(negedge clk);
        #2 reset = 1'b0;
        model_fail = 0;
        #1;
        checks++;
        if (observed() !== 7'd0) begin
            errors++;
            $display("FAIL async_reset_mid_open: got %b required %b", observed(), 7'd0);
        end
        #1 reset = 1'b1;
        enter_code("async_post", GOOD);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (observed() !== e.value) begin
            errors++;
            $display("FAIL %s: got %b required %b", e.name, observed(), e.value);
        end
        wait_unlock_low("async_post");
    endtask

    initial begin
        reset  = 1'b0;
        update = 1'b0;
        key    = 1'b0;
        relock = 1'b0;
        test_reset();
        test_correct();
        test_wrong();
        test_lockout();
        test_relock_open();
        test_relock_entry();
        test_held_strobe();
        test_async_reset();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
